// File: rtl/acumulador_16bits_pkg.sv
// Shared types and default sizes for the signed accumulator and its bench.
// The FSM encoding lives here so checkers and the bench decode state identically.
package acumulador_16bits_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a +/- b given the wrapped result, judged on sign bits only.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic sub);
    logic same_sign;
    same_sign  = (a_msb == b_msb);
    signed_ovf = (sub ? !same_sign : same_sign) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/acumulador_16bits_if.sv
// Operand/result bus of the accumulator. master = operand source and result consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid may not depend on ready, and the source holds data stable until ready is seen.
interface acumulador_16bits_if
  import acumulador_16bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand;
  logic             control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             overflow;
  logic [CNT_W-1:0] conta;

  modport master (
    output clear, in_valid, operand, control, out_ready,
    input  in_ready, out_valid, acc, overflow, conta
  );

  modport slave (
    input  clear, in_valid, operand, control, out_ready,
    output in_ready, out_valid, acc, overflow, conta
  );

endinterface

// File: rtl/sumador_16bits.sv
// Two's-complement adder/subtractor with signed-overflow detection.
// control=0 gives a+b, control=1 gives a-b, both modulo 2^WIDTH.
module sumador_16bits
  import acumulador_16bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             control,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction as a + ~b + 1 so one carry chain serves both operations.
  always_comb begin
    b_eff    = control ? ~b : b;
    result   = a + b_eff + {{(WIDTH-1){1'b0}}, control};
    overflow = signed_ovf(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1], control);
  end

endmodule

// File: rtl/acumulador_16bits.sv
// Signed accumulator: IDLE accepts an operand, EXEC applies it, DONE holds the
// result until the consumer takes it. Sticky overflow and a wrapping op counter.
module acumulador_16bits
  import acumulador_16bits_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  acumulador_16bits_if.slave  bus,
  output state_t              state_o
);

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_q;
  logic             ctl_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  sumador_16bits #(.WIDTH(WIDTH)) u_sumador (
    .a        (acc_q),
    .b        (op_q),
    .control  (ctl_q),
    .result   (sum),
    .overflow (sum_ovf)
  );

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (state_q == EXEC) begin
      acc_d = sum;
      ovf_d = ovf_q | sum_ovf;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // clear behaves like reset but synchronously, dropping any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      ctl_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      ctl_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.operand;
            ctl_q      <= bus.control;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.conta     = cnt_q;
  assign state_o       = state_q;

endmodule
